// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: turns byte/half/word load-store requests into
// word read, read-modify-write and word write cycles on a word-only memory port.
module dm_access_ctrl #(
  parameter int MEM_WORDS  = 1024,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_dr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [31:0] LP_MEM_WORDS = 32'(MEM_WORDS);

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_we;
  logic        r_signed;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        w_err;

  // Lane index of a byte offset / half offset, honouring byte order.
  function automatic logic [1:0] f_byte_lane(input logic [1:0] off);
    return BIG_ENDIAN ? ~off : off;
  endfunction

  function automatic logic f_half_lane(input logic off1);
    return BIG_ENDIAN ? ~off1 : off1;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] wdata,
                                          input logic [1:0] size, input logic [1:0] off);
    logic [31:0] m;
    m = word;
    case (size)
      2'b00:   m[{f_byte_lane(off), 3'b000} +: 8]  = wdata[7:0];
      2'b01:   m[{f_half_lane(off[1]), 4'b0000} +: 16] = wdata[15:0];
      default: m = wdata;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] size,
                                         input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{f_byte_lane(off), 3'b000} +: 8];
    h = word[{f_half_lane(off[1]), 4'b0000} +: 16];
    case (size)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  always_comb begin
    w_err = (req_size == 2'b11)
          | ((req_size == 2'b01) & req_addr[0])
          | ((req_size == 2'b10) & (|req_addr[1:0]))
          | ({2'b00, req_addr[31:2]} >= LP_MEM_WORDS);
  end

  assign req_ready  = (r_state == S_IDLE);
  assign mem_wr     = (r_state == S_WR) & ~rst;
  assign mem_a      = {r_addr[31:2], 2'b00};
  assign mem_wd     = f_merge(r_buf, r_wdata, r_size, r_addr[1:0]);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_size       <= '0;
      r_we         <= 1'b0;
      r_signed     <= 1'b0;
      r_wdata      <= '0;
      r_buf        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_size   <= req_size;
            r_we     <= req_we;
            r_signed <= req_signed;
            r_wdata  <= req_wdata;
            if (w_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (req_we && req_size == 2'b10) begin
              r_state <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          r_buf <= mem_dr;
          if (r_we) begin
            r_state <= S_WR;
          end else begin
            // Extend straight from the memory word; the buffer updates on this same edge.
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= f_load(mem_dr, r_size, r_signed, r_addr[1:0]);
          end
        end
        S_WR: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a small behavioural word memory.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_dr;

  logic [31:0] mem [0:1023];
  logic        pl_en;
  logic [31:0] pl_data;

  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle observations for cycles k+1..k+4 after the accept edge k.
  logic        s_wr [1:4];
  logic [31:0] s_a  [1:4];
  logic [31:0] s_wd [1:4];
  logic        s_rv [1:4];
  logic [31:0] s_rd [1:4];
  logic        s_re [1:4];

  dm_access_ctrl #(.MEM_WORDS(1024), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_wr(mem_wr), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_dr(mem_dr)
  );

  always #5 clk = ~clk;

  assign mem_dr = mem[mem_a[11:2]];

  always @(posedge clk) begin
    if (pl_en) mem[4] <= pl_data;
    else if (mem_wr) mem[mem_a[11:2]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] val);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_data = val;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Issue one request from a negedge and record the four following cycles.
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      s_wr[i] = mem_wr;
      s_a[i]  = mem_a;
      s_wd[i] = mem_wd;
      s_rv[i] = resp_valid;
      s_rd[i] = resp_rdata;
      s_re[i] = resp_err;
    end
  endtask

  task automatic check_err(input string tag);
    check({tag, "_rv1"}, {31'b0, s_rv[1]}, 32'd1);
    check({tag, "_err1"}, {31'b0, s_re[1]}, 32'd1);
    check({tag, "_rd1"}, s_rd[1], 32'h0);
    check({tag, "_rv2"}, {31'b0, s_rv[2]}, 32'd0);
    check({tag, "_nowr"}, {28'b0, s_wr[1], s_wr[2], s_wr[3], s_wr[4]}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    pl_en = 1'b0; pl_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mem_a", mem_a, 32'h0);

    // Word store then word load
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_wr1", {31'b0, s_wr[1]}, 32'd1);
    check("sw_a1", s_a[1], 32'h10);
    check("sw_wd1", s_wd[1], 32'hDEADBEEF);
    check("sw_wr2", {31'b0, s_wr[2]}, 32'd0);
    check("sw_rv1", {31'b0, s_rv[1]}, 32'd0);
    check("sw_rv2", {31'b0, s_rv[2]}, 32'd1);
    check("sw_err2", {31'b0, s_re[2]}, 32'd0);
    check("sw_rv3", {31'b0, s_rv[3]}, 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_rv2", {31'b0, s_rv[2]}, 32'd1);
    check("lw_rd2", s_rd[2], 32'hDEADBEEF);
    check("lw_nowr", {28'b0, s_wr[1], s_wr[2], s_wr[3], s_wr[4]}, 32'h0);
    check("lw_rd3", s_rd[3], 32'h0);

    // Read-modify-write byte and half stores
    preload(32'h11223344);
    run_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB);
    check("sb_wr1", {31'b0, s_wr[1]}, 32'd0);
    check("sb_wr2", {31'b0, s_wr[2]}, 32'd1);
    check("sb_wd2", s_wd[2], 32'h11AB3344);
    check("sb_rv3", {31'b0, s_rv[3]}, 32'd1);
    check("sb_rd3", s_rd[3], 32'h0);
    check("sb_mem", mem[4], 32'h11AB3344);
    preload(32'h11223344);
    run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001);
    check("sh_wr2", {31'b0, s_wr[2]}, 32'd1);
    check("sh_wd2", s_wd[2], 32'h80013344);
    check("sh_rv3", {31'b0, s_rv[3]}, 32'd1);

    // Sub-word loads with sign/zero extension
    preload(32'h80FF7F01);
    run_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    check("lb_s_12", s_rd[2], 32'hFFFFFFFF);
    run_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    check("lbu_12", s_rd[2], 32'h000000FF);
    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lb_s_13", s_rd[2], 32'hFFFFFF80);
    run_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    check("lb_s_10", s_rd[2], 32'h00000001);
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check("lh_s_12", s_rd[2], 32'hFFFF80FF);
    run_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    check("lhu_10", s_rd[2], 32'h00007F01);

    // Error cases
    run_req(1'b0, 2'b01, 1'b1, 32'h13, 32'h0);
    check_err("lh_mis");
    run_req(1'b1, 2'b10, 1'b0, 32'h1002, 32'h12345678);
    check_err("sw_mis");
    run_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    check_err("lw_range");
    run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    check_err("size11");
    run_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    check("lw_last_err", {31'b0, s_re[2]}, 32'd0);
    check("lw_last_rv", {31'b0, s_rv[2]}, 32'd1);

    // Reset during the write cycle of a byte store
    preload(32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h12; req_wdata = 32'hAB;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstwr_mem_wr", {31'b0, mem_wr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rstwr_ready", {31'b0, req_ready}, 32'd1);
    check("rstwr_rv", {31'b0, resp_valid}, 32'd0);
    check("rstwr_mem", mem[4], 32'h11223344);
    @(negedge clk);
    check("rstwr_rv_next", {31'b0, resp_valid}, 32'd0);
    check("rstwr_wr_next", {31'b0, mem_wr}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator side of the data-memory port. It sits between the CPU MEM stage and the word-only data memory.
- The data memory has a combinational word read and a write on the clock edge.
- This block converts byte, halfword and word load/store requests into word read, read-modify-write and word write sequences on that port.
- It checks alignment and range, and returns sign- or zero-extended load data through a valid/ready request and one-cycle response handshake.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the data memory; a word index at or above this value is out of range.
BIG_ENDIAN, 0, byte-lane order: 0 means byte offset 0 is bits [7:0]; 1 means byte offset 0 is bits [31:24].

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request (IDLE only).
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
req_signed  in  1  sign-extend load data (byte/half only).
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
resp_valid  out  1  one-cycle response pulse.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned, out-of-range or illegal size; valid with resp_valid.
mem_wr  out  1  word write strobe to the data memory.
mem_a  out  32  word-aligned address {addr[31:2],2'b00}.
mem_wd  out  32  merged write word.
mem_dr  in  32  combinational read word from the data memory.

Behaviour:
- Reset is synchronous: rst=1 at a clock edge forces the following state.
  - state = IDLE.
  - Latched addr, size, we, signed, wdata and the read buffer all = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
- mem_wr = (state==WR) & ~rst. A reset in the WR cycle therefore suppresses the write.
- States are IDLE, RD, WR and RESP. req_ready = (state==IDLE).
- IDLE: when req_valid=1, latch all request fields at the edge and evaluate the error condition.
  - Error when any of these holds:
    - req_size=11;
    - size=01 with addr[0]=1;
    - size=10 with addr[1:0]!=0;
    - addr[31:2] >= MEM_WORDS.
  - On error: go to RESP with err=1. No memory cycle is issued.
  - Load: go to RD.
  - Word store: go to WR.
  - Byte or half store: go to RD.
- RD: mem_a = latched aligned address, mem_wr=0. Capture mem_dr into the read buffer at the edge.
  - Load: go to RESP.
  - Store: go to WR.
- WR: mem_wr=1 for exactly one cycle with mem_wd = merged word, then go to RESP.
  - Word store: merged word = wdata.
  - Byte store: replace the selected byte lane of the buffer with wdata[7:0].
  - Half store: replace the selected half lane (offset addr[1]) with wdata[15:0].
  - Lane selection follows BIG_ENDIAN.
- RESP: resp_valid=1 for one cycle, then go to IDLE.
  - resp_rdata is the selected lane of the buffer.
  - Byte and half loads are zero- or sign-extended per the latched signed bit; word loads return the full word.
  - resp_rdata = 0 for stores and errors.
  - resp_valid, resp_rdata and resp_err are registered and return to 0 the cycle after the pulse.
- Latency, measured from the accept edge k to the resp_valid cycle:
  - error: cycle k+1;
  - load: RD in k+1, response in k+2;
  - sw: WR in k+1, response in k+2;
  - sb/sh: RD in k+1, WR in k+2, response in k+3.
- Outside IDLE, req_valid is ignored. The requester holds its request until req_ready=1.
- Back-to-back requests: a new request is accepted in the IDLE cycle immediately after RESP.
- mem_a holds the latched address in all states; it is don't-care when not in RD or WR.

Test Plan:
- Reset: rst held 2 cycles, then released -> req_ready=1, mem_wr=0, resp_valid=0; mem_a=0.
- sw addr=0x10 wdata=0xDEADBEEF -> mem_wr high exactly in cycle k+1 with mem_a=0x10 and mem_wd=0xDEADBEEF; then lw 0x10 -> resp_rdata=0xDEADBEEF in cycle k+2.
- Memory word 0x10 = 0x11223344 (BIG_ENDIAN=0):
  - sb addr=0x12 wdata=0xAB -> mem_wd=0x11AB3344 in cycle k+2;
  - sh addr=0x12 wdata=0x8001 -> mem_wd=0x80013344.
- Word 0x10 = 0x80FF7F01:
  - lb signed at 0x12 -> 0xFFFFFFFF;
  - lbu at 0x12 -> 0x000000FF;
  - lh signed at 0x12 -> 0xFFFF80FF;
  - lhu at 0x10 -> 0x00007F01.
- Errors:
  - lh addr=0x13 -> resp_err=1 in k+1, resp_rdata=0, no mem_wr;
  - sw addr=0x1002 -> err;
  - lw addr=0x1000 with MEM_WORDS=1024 -> err;
  - req_size=11 -> err.
- Reset mid-operation: assert rst during the WR cycle of an sb -> mem_wr=0, memory word unchanged, next cycle req_ready=1 and no resp_valid.
